// File: rtl/hacd_pkg.sv
// Shared FSM state type, completion error codes and AXI burst constants for the
// hawk cacheline AXI master.
`ifndef HACD_MC_AXI4_DATA_WIDTH
`define HACD_MC_AXI4_DATA_WIDTH 256
`endif

package hacd_pkg;
    typedef enum logic [3:0] {IDLE, AW, W0, W1, BWAIT, AR, R0, R1, RSP} cl_state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_AXI = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    localparam logic [7:0] AXI_LEN        = 8'd1;
    localparam logic [2:0] AXI_SIZE       = 3'd5;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam int LINE_W = 512;
    localparam int BEAT_W = `HACD_MC_AXI4_DATA_WIDTH;
endpackage

// File: rtl/hawk_cl_axi_master_if.sv
// AXI4 write and read channel bundles between the cacheline master and the memory
// controller; the line is carried as two BEAT_W beats.
interface HACD_MC_AXI_WR_BUS #(parameter int ID_W = 6) ();
    logic                          awvalid, awready;
    logic [63:0]                   awaddr;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic [ID_W-1:0]               awid;
    logic                          wvalid, wready, wlast;
    logic [hacd_pkg::BEAT_W-1:0]   wdata;
    logic [hacd_pkg::BEAT_W/8-1:0] wstrb;
    logic                          bvalid, bready;
    logic [1:0]                    bresp;
    logic [ID_W-1:0]               bid;

    modport master(output awvalid, awaddr, awlen, awsize, awburst, awid,
                          wvalid, wdata, wstrb, wlast, bready,
                   input  awready, wready, bvalid, bresp, bid);
    modport slave (input  awvalid, awaddr, awlen, awsize, awburst, awid,
                          wvalid, wdata, wstrb, wlast, bready,
                   output awready, wready, bvalid, bresp, bid);
endinterface

interface HACD_MC_AXI_RD_BUS #(parameter int ID_W = 6) ();
    logic                        arvalid, arready;
    logic [63:0]                 araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic [ID_W-1:0]             arid;
    logic                        rvalid, rready, rlast;
    logic [hacd_pkg::BEAT_W-1:0] rdata;
    logic [1:0]                  rresp;
    logic [ID_W-1:0]             rid;

    modport master(output arvalid, araddr, arlen, arsize, arburst, arid, rready,
                   input  arready, rvalid, rdata, rresp, rid, rlast);
    modport slave (input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
                   output arready, rvalid, rdata, rresp, rid, rlast);
endinterface

// File: rtl/hawk_line_byteswap.sv
// 512-bit line byte reorder. With HAWK_CL_BYTESWAP_EN defined each 8-byte word is
// byte-reversed (memory's big-endian 8B layout); otherwise the line passes straight through.
module hawk_line_byteswap
    import hacd_pkg::*;
(
    input  logic [LINE_W-1:0] din,
    output logic [LINE_W-1:0] dout
);
`ifdef HAWK_CL_BYTESWAP_EN
    for (genvar w = 0; w < LINE_W/64; w++) begin : g_word
        for (genvar b = 0; b < 8; b++) begin : g_byte
            assign dout[64*w + 8*b +: 8] = din[64*w + 8*(7-b) +: 8];
        end
    end
`else
    assign dout = din;
`endif
endmodule

// File: rtl/hawk_cl_axi_master.sv
// Single-outstanding cacheline (64B) AXI4 master: one 2-beat INCR burst per request.
// Optional HAWK_CL_BYTESWAP_EN reorders bytes within 8B words on both directions.
module hawk_cl_axi_master
    import hacd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int ID_W        = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [63:0]         req_addr,
    input  logic [ID_W-1:0]     req_id,
    input  logic [LINE_W-1:0]   req_wdata,
    input  logic [LINE_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [LINE_W-1:0]   rsp_rdata,
    output logic [ID_W-1:0]     rsp_id,
    output logic [1:0]          rsp_err,
    HACD_MC_AXI_WR_BUS.master   wr_bus,
    HACD_MC_AXI_RD_BUS.master   rd_bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    cl_state_t             state;
    logic [LINE_W-1:0]     wline, rline, wdata_sw, wstrb_exp, wstrb_sw;
    logic [LINE_W/8-1:0]   wstrb_line, wstrb_c;
    logic [TMO_W-1:0]      tmo;
    logic                  tmo_hit;

    // Strobes ride through the same byte reorder as data: expand to byte masks, swap, fold back.
    for (genvar k = 0; k < LINE_W/8; k++) begin : g_strb
        assign wstrb_exp[8*k +: 8] = {8{req_wstrb[k]}};
        assign wstrb_c[k]          = &wstrb_sw[8*k +: 8];
    end

    hawk_line_byteswap u_wdata_sw (.din(req_wdata), .dout(wdata_sw));
    hawk_line_byteswap u_wstrb_sw (.din(wstrb_exp), .dout(wstrb_sw));
    hawk_line_byteswap u_rdata_sw (.din(rline),     .dout(rsp_rdata));

    assign tmo_hit = (tmo == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            req_ready          <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_id             <= '0;
            rsp_err            <= ERR_OK;
            wline              <= '0;
            wstrb_line         <= '0;
            rline              <= '0;
            tmo                <= '0;
            wr_bus.awvalid     <= 1'b0;
            wr_bus.awaddr      <= '0;
            wr_bus.awlen       <= '0;
            wr_bus.awsize      <= '0;
            wr_bus.awburst     <= '0;
            wr_bus.awid        <= '0;
            wr_bus.wvalid      <= 1'b0;
            wr_bus.wdata       <= '0;
            wr_bus.wstrb       <= '0;
            wr_bus.wlast       <= 1'b0;
            wr_bus.bready      <= 1'b0;
            rd_bus.arvalid     <= 1'b0;
            rd_bus.araddr      <= '0;
            rd_bus.arlen       <= '0;
            rd_bus.arsize      <= '0;
            rd_bus.arburst     <= '0;
            rd_bus.arid        <= '0;
            rd_bus.rready      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready rises one cycle after entering IDLE, giving the idle gap after a response.
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        rsp_id    <= req_id;
                        rsp_err   <= ERR_OK;
                        rline     <= '0;
                        if (req_wr) begin
                            wline           <= wdata_sw;
                            wstrb_line      <= wstrb_c;
                            wr_bus.awvalid  <= 1'b1;
                            wr_bus.awaddr   <= req_addr;
                            wr_bus.awlen    <= AXI_LEN;
                            wr_bus.awsize   <= AXI_SIZE;
                            wr_bus.awburst  <= AXI_BURST_INCR;
                            wr_bus.awid     <= req_id;
                            state           <= AW;
                        end else begin
                            rd_bus.arvalid  <= 1'b1;
                            rd_bus.araddr   <= req_addr;
                            rd_bus.arlen    <= AXI_LEN;
                            rd_bus.arsize   <= AXI_SIZE;
                            rd_bus.arburst  <= AXI_BURST_INCR;
                            rd_bus.arid     <= req_id;
                            state           <= AR;
                        end
                    end
                end
                AW: if (wr_bus.awready) begin
                    wr_bus.awvalid <= 1'b0;
                    wr_bus.wvalid  <= 1'b1;
                    wr_bus.wdata   <= wline[BEAT_W-1:0];
                    wr_bus.wstrb   <= wstrb_line[BEAT_W/8-1:0];
                    wr_bus.wlast   <= 1'b0;
                    state          <= W0;
                end
                W0: if (wr_bus.wready) begin
                    wr_bus.wdata <= wline[LINE_W-1:BEAT_W];
                    wr_bus.wstrb <= wstrb_line[LINE_W/8-1:BEAT_W/8];
                    wr_bus.wlast <= 1'b1;
                    state        <= W1;
                end
                W1: if (wr_bus.wready) begin
                    wr_bus.wvalid <= 1'b0;
                    wr_bus.wlast  <= 1'b0;
                    wr_bus.bready <= 1'b1;
                    tmo           <= '0;
                    state         <= BWAIT;
                end
                BWAIT: if (wr_bus.bvalid) begin
                    wr_bus.bready <= 1'b0;
                    rsp_valid     <= 1'b1;
                    state         <= RSP;
                    if (wr_bus.bresp != 2'b00 || wr_bus.bid != rsp_id) rsp_err <= ERR_AXI;
                end else if (tmo_hit) begin
                    wr_bus.bready <= 1'b0;
                    rsp_err       <= ERR_TMO;
                    rsp_valid     <= 1'b1;
                    state         <= RSP;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                AR: if (rd_bus.arready) begin
                    rd_bus.arvalid <= 1'b0;
                    rd_bus.rready  <= 1'b1;
                    tmo            <= '0;
                    state          <= R0;
                end
                R0: if (rd_bus.rvalid) begin
                    rline[BEAT_W-1:0] <= rd_bus.rdata;
                    tmo               <= '0;
                    state             <= R1;
                    if (rd_bus.rresp != 2'b00 || rd_bus.rlast || rd_bus.rid != rsp_id) rsp_err <= ERR_AXI;
                end else if (tmo_hit) begin
                    rd_bus.rready <= 1'b0;
                    rsp_err       <= ERR_TMO;
                    rsp_valid     <= 1'b1;
                    state         <= RSP;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                R1: if (rd_bus.rvalid) begin
                    rline[LINE_W-1:BEAT_W] <= rd_bus.rdata;
                    rd_bus.rready          <= 1'b0;
                    rsp_valid              <= 1'b1;
                    state                  <= RSP;
                    if (rd_bus.rresp != 2'b00 || !rd_bus.rlast || rd_bus.rid != rsp_id) rsp_err <= ERR_AXI;
                end else if (tmo_hit) begin
                    rd_bus.rready <= 1'b0;
                    rsp_err       <= ERR_TMO;
                    rsp_valid     <= 1'b1;
                    state         <= RSP;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hawk_cl_axi_master.sv
// Bench for hawk_cl_axi_master: vector table driven through an in-bench AXI slave,
// completions checked against a scoreboard queue, plus reset and timeout corner sequences.
module tb_hawk_cl_axi_master;
    import hacd_pkg::*;

    localparam int ID_W = 6;
    localparam int TMO  = 1024;
`ifdef HAWK_CL_BYTESWAP_EN
    localparam int B0_SRC = 7;
`else
    localparam int B0_SRC = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [63:0]      req_addr = '0;
    logic [ID_W-1:0]  req_id = '0;
    logic [511:0]     req_wdata = '0;
    logic [63:0]      req_wstrb = '0;
    logic             rsp_valid, rsp_ready = 1'b0;
    logic [511:0]     rsp_rdata;
    logic [ID_W-1:0]  rsp_id;
    logic [1:0]       rsp_err;

    always #5 clk = ~clk;

    HACD_MC_AXI_WR_BUS #(.ID_W(ID_W)) wr_bus ();
    HACD_MC_AXI_RD_BUS #(.ID_W(ID_W)) rd_bus ();

    hawk_cl_axi_master #(.TIMEOUT_CYC(TMO), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_id(req_id), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .wr_bus(wr_bus), .rd_bus(rd_bus)
    );

    typedef struct {
        bit              wr;
        logic [63:0]     addr;
        logic [ID_W-1:0] id;
        logic [511:0]    wdata;
        logic [63:0]     wstrb;
        int              ready_dly;   // awready/arready delay
        int              rsp_dly;     // rsp_ready held low
        logic [1:0]      resp0;       // rresp beat 0
        logic [1:0]      resp1;       // rresp beat 1 / bresp
        int              rlast_mode;  // 0 normal, 1 rlast on beat 0, 2 rlast missing on beat 1
        bit              bad_id;
        bit              b_never;
        logic [1:0]      exp_err;
    } vec_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      err;
        logic [511:0]    rdata;
    } exp_t;

    int            checks = 0, failures = 0;
    exp_t          sb[$];
    logic [511:0]  mem [logic [63:0]];
    vec_t          vt[12];
    logic [511:0]  line0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] bus_line(input logic [511:0] l);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = l[8*((i/8)*8 + ((i%8) ^ B0_SRC)) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] bus_strb(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = s[(i/8)*8 + ((i%8) ^ B0_SRC)];
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] get_line(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    function automatic vec_t mk(bit wr, logic [63:0] addr, logic [ID_W-1:0] id, logic [511:0] wd,
                                logic [63:0] ws, int rdly, int sdly, logic [1:0] r0, logic [1:0] r1,
                                int rlm, bit bid, bit bnev, logic [1:0] ee);
        vec_t v;
        v.wr = wr; v.addr = addr; v.id = id; v.wdata = wd; v.wstrb = ws;
        v.ready_dly = rdly; v.rsp_dly = sdly; v.resp0 = r0; v.resp1 = r1;
        v.rlast_mode = rlm; v.bad_id = bid; v.b_never = bnev; v.exp_err = ee;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        exp_t            e, got;
        logic [511:0]    line, bl;
        logic [63:0]     bs;
        logic [ID_W-1:0] rid;
        bit              stable;
        int              n;
        line = get_line(v.addr);
        if (v.wr) begin
            for (int k = 0; k < 64; k++) if (v.wstrb[k]) line[8*k +: 8] = v.wdata[8*k +: 8];
            mem[v.addr] = line;
            e.rdata = '0;
        end else begin
            e.rdata = line;
        end
        e.id = v.id; e.err = v.exp_err;
        rid  = v.bad_id ? (v.id ^ 6'd1) : v.id;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_id = v.id;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 0);
        if (v.wr) begin
            bl = bus_line(v.wdata);
            bs = bus_strb(v.wstrb);
            n = 0;
            while (!wr_bus.awvalid && n < 50) begin @(negedge clk); n++; end
            chk("awvalid", wr_bus.awvalid, 1);
            chk("awaddr", wr_bus.awaddr, v.addr);
            chk("awlen", wr_bus.awlen, 1);
            chk("awsize", wr_bus.awsize, 5);
            chk("awburst", wr_bus.awburst, 1);
            chk("awid", wr_bus.awid, v.id);
            stable = !wr_bus.wvalid;
            for (int i = 0; i < v.ready_dly; i++) begin
                @(negedge clk);
                if (!wr_bus.awvalid || wr_bus.awaddr !== v.addr || wr_bus.awid !== v.id ||
                    wr_bus.awlen !== 8'd1 || wr_bus.wvalid) stable = 0;
            end
            chk("aw_stable_no_w", stable, 1);
            wr_bus.awready = 1'b1;
            @(negedge clk);
            wr_bus.awready = 1'b0;
            chk("awvalid_drop", wr_bus.awvalid, 0);
            chk("w0_valid", wr_bus.wvalid, 1);
            chk("w0_last", wr_bus.wlast, 0);
            chk("w0_data", wr_bus.wdata, bl[255:0]);
            chk("w0_strb", wr_bus.wstrb, bs[31:0]);
            chk("w0_byte0", wr_bus.wdata[7:0], v.wdata[8*B0_SRC +: 8]);
            @(negedge clk);
            chk("w1_valid", wr_bus.wvalid, 1);
            chk("w1_last", wr_bus.wlast, 1);
            chk("w1_data", wr_bus.wdata, bl[511:256]);
            chk("w1_strb", wr_bus.wstrb, bs[63:32]);
            @(negedge clk);
            chk("w_done", wr_bus.wvalid, 0);
            chk("bready", wr_bus.bready, 1);
            if (v.b_never) begin
                n = 0;
                while (wr_bus.bready && n < TMO + 50) begin @(negedge clk); n++; end
                chk("tmo_bready_cycles", n, TMO);
                chk("tmo_rsp_valid", rsp_valid, 1);
            end else begin
                wr_bus.bvalid = 1'b1; wr_bus.bresp = v.resp1; wr_bus.bid = rid;
                @(negedge clk);
                wr_bus.bvalid = 1'b0;
                chk("bready_drop", wr_bus.bready, 0);
            end
        end else begin
            bl = bus_line(line);
            n = 0;
            while (!rd_bus.arvalid && n < 50) begin @(negedge clk); n++; end
            chk("arvalid", rd_bus.arvalid, 1);
            chk("araddr", rd_bus.araddr, v.addr);
            chk("arlen", rd_bus.arlen, 1);
            chk("arsize", rd_bus.arsize, 5);
            chk("arburst", rd_bus.arburst, 1);
            chk("arid", rd_bus.arid, v.id);
            stable = 1;
            for (int i = 0; i < v.ready_dly; i++) begin
                @(negedge clk);
                if (!rd_bus.arvalid || rd_bus.araddr !== v.addr || rd_bus.arid !== v.id) stable = 0;
            end
            chk("ar_stable", stable, 1);
            rd_bus.arready = 1'b1;
            @(negedge clk);
            rd_bus.arready = 1'b0;
            chk("rready0", rd_bus.rready, 1);
            rd_bus.rvalid = 1'b1; rd_bus.rdata = bl[255:0]; rd_bus.rresp = v.resp0;
            rd_bus.rid = rid; rd_bus.rlast = (v.rlast_mode == 1);
            @(negedge clk);
            chk("rready1", rd_bus.rready, 1);
            rd_bus.rdata = bl[511:256]; rd_bus.rresp = v.resp1; rd_bus.rlast = (v.rlast_mode != 2);
            @(negedge clk);
            rd_bus.rvalid = 1'b0; rd_bus.rlast = 1'b0; rd_bus.rresp = 2'b00;
            chk("rready_drop", rd_bus.rready, 0);
        end
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("rsp_valid", rsp_valid, 1);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("rsp_id", rsp_id, got.id);
            chk("rsp_err", rsp_err, got.err);
            chk("rsp_rdata", rsp_rdata, got.rdata);
            stable = 1;
            for (int i = 0; i < v.rsp_dly; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_id !== got.id || rsp_err !== got.err || rsp_rdata !== got.rdata)
                    stable = 0;
            end
            chk("rsp_stable", stable, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("idle_gap", req_ready, 0);
        @(negedge clk);
        chk("req_ready_back", req_ready, 1);
    endtask

    initial begin
        wr_bus.awready = 1'b0; wr_bus.wready = 1'b1; wr_bus.bvalid = 1'b0;
        wr_bus.bresp = 2'b00; wr_bus.bid = '0;
        rd_bus.arready = 1'b0; rd_bus.rvalid = 1'b0; rd_bus.rdata = '0;
        rd_bus.rresp = 2'b00; rd_bus.rid = '0; rd_bus.rlast = 1'b0;
        for (int k = 0; k < 64; k++) line0[8*k +: 8] = 8'(k);

        //       wr addr       id  wdata     wstrb                  rdly sdly r0 r1 rlm bid bnev exp
        vt[0]  = mk(1, 64'h1000, 5,  line0,    '1,                    0, 0, 0, 0, 0, 0, 0, ERR_OK);
        vt[1]  = mk(0, 64'h1000, 6,  '0,       '0,                    0, 0, 0, 0, 0, 0, 0, ERR_OK);
        vt[2]  = mk(1, 64'h2040, 7,  rnd512(), 64'h00FF_0000_F0F0_0001, 0, 0, 0, 2, 0, 0, 0, ERR_AXI);
        vt[3]  = mk(0, 64'h2040, 8,  '0,       '0,                    0, 0, 0, 2, 0, 0, 0, ERR_AXI);
        vt[4]  = mk(0, 64'h1000, 9,  '0,       '0,                    0, 0, 0, 0, 1, 0, 0, ERR_AXI);
        vt[5]  = mk(0, 64'h1000, 10, '0,       '0,                    0, 0, 0, 0, 2, 0, 0, ERR_AXI);
        vt[6]  = mk(0, 64'h1000, 11, '0,       '0,                    0, 0, 0, 0, 0, 1, 0, ERR_AXI);
        vt[7]  = mk(1, 64'h1000, 12, rnd512(), 64'hFFFF_0000_0000_FFFF, 0, 0, 0, 0, 0, 1, 0, ERR_AXI);
        vt[8]  = mk(1, 64'h1040, 13, rnd512(), '1,                    5, 3, 0, 0, 0, 0, 0, ERR_OK);
        vt[9]  = mk(0, 64'h1000, 14, '0,       '0,                    3, 2, 0, 0, 0, 0, 0, ERR_OK);
        vt[10] = mk(1, 64'h3000, 15, rnd512(), '1,                    0, 0, 0, 0, 0, 0, 1, ERR_TMO);
        vt[11] = mk(0, 64'h1040, 16, '0,       '0,                    0, 1, 0, 0, 0, 0, 0, ERR_OK);

        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_awvalid", wr_bus.awvalid, 0);
        chk("reset_wvalid", wr_bus.wvalid, 0);
        chk("reset_arvalid", rd_bus.arvalid, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", req_ready, 1);

        for (int i = 0; i < 12; i++) run_txn(vt[i]);

        // Reset while the second write beat is on the bus.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 64'h4000; req_id = 6'd3;
        req_wdata = line0; req_wstrb = '1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_seq_awvalid", wr_bus.awvalid, 1);
        wr_bus.awready = 1'b1;
        @(negedge clk);
        wr_bus.awready = 1'b0;
        @(negedge clk);
        chk("rst_seq_in_w1", wr_bus.wlast, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_w1_wvalid", wr_bus.wvalid, 0);
        chk("rst_w1_wlast", wr_bus.wlast, 0);
        chk("rst_w1_wdata", wr_bus.wdata, 0);
        chk("rst_w1_bready", wr_bus.bready, 0);
        chk("rst_w1_req_ready", req_ready, 0);
        chk("rst_w1_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_w1_req_ready_after", req_ready, 1);
        run_txn(vt[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hawk_cl_axi_master.md
HAWK_CL_AXI_MASTER -- requirements
Module: hawk_cl_axi_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, meaning max cycles waiting for B or R beat before error completion.
REQ-002 SHALL have parameter ID_W, default 6, meaning AXI ID width.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid/req_ready  in/out  1/1  cacheline request handshake.
REQ-006 SHALL have port req_wr  in  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  in  64  cacheline address, 64B aligned.
REQ-008 SHALL have port req_id  in  ID_W  transaction tag.
REQ-009 SHALL have port req_wdata/req_wstrb  in  512/64  write line and byte enables; byte k of line = bit 8k.
REQ-010 SHALL have port rsp_valid/rsp_ready  out/in  1/1  completion handshake.
REQ-011 SHALL have port rsp_rdata/rsp_id/rsp_err  out  512/ID_W/2  read line, tag, error (00 ok, 01 AXI SLVERR/DECERR, 10 timeout).
REQ-012 SHALL have port wr_bus  master modport of HACD_MC_AXI_WR_BUS; rd_bus  master modport of HACD_MC_AXI_RD_BUS; data width `HACD_MC_AXI4_DATA_WIDTH (256).

Function
REQ-013 SHALL accept one request at a time; req_ready=1 only in IDLE.
REQ-014 SHALL register request on req_valid&req_ready; issue AXI on next cycle.
REQ-015 SHALL use states IDLE, AW, W0, W1, BWAIT, AR, R0, R1, RSP.
REQ-016 Write: AW drives awvalid, awaddr=req_addr, awlen=1, awsize=5, awburst=INCR, awid=req_id; stay until awready.
REQ-017 W0 SHALL drive wvalid, wdata=line[255:0], wstrb=strb[31:0], wlast=0; W1 line[511:256], strb[63:32], wlast=1; each beat advances only on wready.
REQ-018 SHALL never assert wvalid before the AW handshake cycle completes.
REQ-019 BWAIT SHALL hold bready=1; on bvalid capture bresp, go RSP with rsp_err=01 if bresp!=0.
REQ-020 Read: AR drives arvalid, arlen=1, arsize=5, arburst=INCR, arid=req_id; until arready.
REQ-021 R0/R1 SHALL hold rready=1; capture rdata into line low/high half on rvalid; any rresp!=0 sets err=01.
REQ-022 rlast in R0 or missing in R1 SHALL set err=01; R1 still completes on rvalid.
REQ-023 rid/bid not equal to issued id SHALL set err=01.
REQ-024 Timeout counter SHALL reset on entry to BWAIT/R0/R1 and on each accepted beat; reaching TIMEOUT_CYC SHALL go RSP with err=10, dropping bready/rready.
REQ-025 RSP SHALL hold rsp_valid and stable outputs until rsp_ready; then IDLE; writes return rsp_rdata=0.
REQ-026 All AXI valid signals SHALL stay asserted with stable payload until their ready.
REQ-027 Back-to-back requests: minimum 1 idle cycle between rsp handshake and next req_ready.

Reset
REQ-028 rst_n=0 at posedge SHALL force IDLE, counters 0, and all valid/ready/last outputs 0, rsp_* 0, AXI payload 0, including mid-burst.
REQ-029 req_ready SHALL be 0 during reset and 1 the first cycle after.

Configuration
REQ-030 Macro HAWK_CL_BYTESWAP_EN defined: SHALL byte-reverse each 8-byte word of wdata/wstrb before AXI and of rdata before rsp_rdata (memory's big-endian 8B layout).
REQ-031 Macro undefined: data and strobes pass unmodified.

Structure
REQ-032 State enum, err codes, AXI len/size/burst constants SHALL live in hacd_pkg.
REQ-033 Byte swap SHALL be sub-module hawk_line_byteswap (512-bit combinational, reused for wdata, wstrb-expanded, rdata).

Verification
REQ-034 Write 0x1000, wdata 0..63 bytes, wstrb all 1s, memory model ready always -> 2 W beats, wlast on 2nd, rsp_err=00 after bvalid.
REQ-035 Write then read 0x1000 -> rsp_rdata equals written line; with HAWK_CL_BYTESWAP_EN, AXI beat 0 byte0 = line byte7.
REQ-036 Read with rresp=2 on beat 1 -> rsp_err=01, R1 completes, FSM returns IDLE.
REQ-037 Hold bvalid low 1024 cycles -> rsp_err=10 at cycle 1024, bready drops.
REQ-038 Deassert rst_n during W1 -> next cycle wvalid=0, req_ready=1 after release.
REQ-039 awready delayed 5 cycles, rsp_ready held low 3 cycles -> awvalid/payload and rsp_* stable throughout.
